min_dq_selector: RTL and testbench
==================================

MIN_DQ_SELECTOR -- requirements
Module: min_dq_selector

Interface
REQ-001 SHALL have parameter Q, default 8, meaning the number of parallel PE results per frame.
REQ-002 SHALL have parameter ACC_WIDTH, default 48, meaning the signed distance width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start_frame, input, 1 bit: one-cycle pulse that opens a new collection frame.
REQ-006 SHALL have port pe_valid_in, input, Q bits: per-PE result-valid pulse.
REQ-007 SHALL have port d_q_in_flat, input, ACC_WIDTH*Q bits, signed: per-PE distance; slice i belongs to PE i.
REQ-008 SHALL have ports mImin1_in_flat, mQmin1_in_flat, mImin2_in_flat and mQmin2_in_flat, input, 2*Q bits each: per-PE symbol indices.
REQ-009 SHALL have port d_min_out, output, ACC_WIDTH bits, signed: minimum distance of the frame.
REQ-010 SHALL have port q_best_out, output, clog2(Q) bits: index of the winning PE.
REQ-011 SHALL have ports mImin1_out, mQmin1_out, mImin2_out and mQmin2_out, output, 2 bits each: the winning PE's indices.
REQ-012 SHALL have port valid_out, output, 1 bit: one-cycle result strobe.
REQ-013 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, COLLECT and COMPARE.
REQ-015 IDLE: start_frame SHALL clear all Q captured flags and move to COLLECT; pe_valid_in SHALL be ignored in IDLE.
REQ-016 start_frame SHALL be ignored in COLLECT and COMPARE.
REQ-017 COLLECT: for each i with pe_valid_in[i]=1 and flag[i]=0, the block SHALL store slice i of every input and set flag[i].
REQ-018 A repeated valid from an already-captured PE SHALL be ignored; the first capture wins.
REQ-019 Multiple PEs SHALL be capturable in the same cycle.
REQ-020 On the edge where flags become all-ones (counting captures made on that edge), the state SHALL go to COMPARE with idx=0.
REQ-021 COMPARE SHALL process one entry per cycle, idx 0..Q-1.
REQ-022 At idx=0 the running best SHALL load entry 0 unconditionally.
REQ-023 For idx>0, entry idx SHALL replace the running best only if its d_q is strictly less (signed compare), so ties keep the lower index.
REQ-024 On the edge processing idx=Q-1, the block SHALL register the final best into all outputs, pulse valid_out=1 for exactly one cycle, and return to IDLE.
REQ-025 Latency: valid_out SHALL be high in the cycle after the Q-th edge following the edge that sampled the last outstanding pe_valid_in.
REQ-026 Output data SHALL hold its value until the next frame's result is written.
REQ-027 busy SHALL be registered and track state != IDLE.
REQ-028 No arithmetic SHALL be performed on d_q; the compare is full-width signed with no saturation.

Reset
REQ-029 rst SHALL force state to IDLE and clear all flags, idx and the running best.
REQ-030 rst SHALL force d_min_out=0, q_best_out=0, all m*_out=0, valid_out=0 and busy=0.
REQ-031 rst asserted mid-COLLECT or mid-COMPARE SHALL abort the frame with no valid_out; the next start_frame after reset SHALL begin a clean frame.

Structure
REQ-032 A shared package SHALL hold Q, ACC_WIDTH, the index width clog2(Q), and the FSM state encodings.
REQ-033 Per-PE capture registers and flags SHALL be placed in a single sub-module, dq_capture_bank; compare and FSM logic SHALL stay in the top.

Verification
REQ-034 Q=8; start_frame, then all valids in one cycle with d_q={100,90,80,70,60,50,40,30} -> q_best_out=7, d_min_out=30, valid_out high 8 edges after capture, for one cycle.
REQ-035 Staggered valids over 20 cycles with q3=-5 and all others positive -> q_best_out=3, d_min_out=-5, and the m*_out values equal PE3's inputs.
REQ-036 q2=10 and q5=10 are the minimum -> q_best_out=2.
REQ-037 PE1 is valid with 50, then valid again with 1, all others 20 -> d_min_out=20, q_best_out=0; the second PE1 value is ignored.
REQ-038 rst pulsed at COMPARE idx=4 -> no valid_out, all outputs 0, busy=0; a following frame completes correctly.
REQ-039 start_frame pulsed while busy=1 -> no effect on flags or result; pe_valid_in while IDLE -> nothing captured.

Source files
------------

// File: rtl/min_dq_selector_pkg.sv
// Shared sizing constants and FSM encoding for the
// minimum-distance selector.
package min_dq_selector_pkg;

  localparam int Q_DEF     = 8;
  localparam int ACC_W_DEF = 48;
  localparam int IDX_W_DEF = $clog2(Q_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMPARE = 2'd2
  } state_t;

endpackage

// File: rtl/min_dq_selector_capture.sv
// Per-PE capture bank: first valid result of each PE in a
// frame is latched and its flag set; repeats are dropped.
module dq_capture_bank
  import min_dq_selector_pkg::*;
#(
  parameter int Q         = Q_DEF,
  parameter int ACC_WIDTH = ACC_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [Q-1:0]           valid_i,
  input  logic [ACC_WIDTH*Q-1:0] d_i,
  input  logic [2*Q-1:0]         mi1_i,
  input  logic [2*Q-1:0]         mq1_i,
  input  logic [2*Q-1:0]         mi2_i,
  input  logic [2*Q-1:0]         mq2_i,
  output logic [ACC_WIDTH*Q-1:0] d_o,
  output logic [2*Q-1:0]         mi1_o,
  output logic [2*Q-1:0]         mq1_o,
  output logic [2*Q-1:0]         mi2_o,
  output logic [2*Q-1:0]         mq2_o,
  output logic                   full_o
);

  logic [Q-1:0] flags_q;
  logic [Q-1:0] flags_d;
  logic [Q-1:0] take;

  // full_o looks ahead so captures on this edge count
  always_comb begin
    take    = en_i ? (valid_i & ~flags_q) : '0;
    flags_d = clear_i ? '0 : (flags_q | take);
    full_o  = &flags_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      d_o     <= '0;
      mi1_o   <= '0;
      mq1_o   <= '0;
      mi2_o   <= '0;
      mq2_o   <= '0;
    end else begin
      flags_q <= flags_d;
      for (int i = 0; i < Q; i++) begin
        if (take[i]) begin
          d_o[i*ACC_WIDTH +: ACC_WIDTH] <=
            d_i[i*ACC_WIDTH +: ACC_WIDTH];
          mi1_o[2*i +: 2] <= mi1_i[2*i +: 2];
          mq1_o[2*i +: 2] <= mq1_i[2*i +: 2];
          mi2_o[2*i +: 2] <= mi2_i[2*i +: 2];
          mq2_o[2*i +: 2] <= mq2_i[2*i +: 2];
        end
      end
    end
  end

endmodule

// File: rtl/min_dq_selector.sv
// Collects Q PE distance results per frame, then scans them
// one per cycle for the signed minimum (lowest index wins ties).
module min_dq_selector
  import min_dq_selector_pkg::*;
#(
  parameter int Q         = Q_DEF,
  parameter int ACC_WIDTH = ACC_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_frame,
  input  logic [Q-1:0]                pe_valid_in,
  input  logic [ACC_WIDTH*Q-1:0]      d_q_in_flat,
  input  logic [2*Q-1:0]              mImin1_in_flat,
  input  logic [2*Q-1:0]              mQmin1_in_flat,
  input  logic [2*Q-1:0]              mImin2_in_flat,
  input  logic [2*Q-1:0]              mQmin2_in_flat,
  output logic signed [ACC_WIDTH-1:0] d_min_out,
  output logic [$clog2(Q)-1:0]        q_best_out,
  output logic [1:0]                  mImin1_out,
  output logic [1:0]                  mQmin1_out,
  output logic [1:0]                  mImin2_out,
  output logic [1:0]                  mQmin2_out,
  output logic                        valid_out,
  output logic                        busy
);

  localparam int QW = $clog2(Q);

  logic [ACC_WIDTH*Q-1:0] cap_d;
  logic [2*Q-1:0] cap_mi1, cap_mq1, cap_mi2, cap_mq2;
  logic cap_full, cap_clear, cap_en;

  dq_capture_bank #(
    .Q         (Q),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .clear_i (cap_clear),
    .en_i    (cap_en),
    .valid_i (pe_valid_in),
    .d_i     (d_q_in_flat),
    .mi1_i   (mImin1_in_flat),
    .mq1_i   (mQmin1_in_flat),
    .mi2_i   (mImin2_in_flat),
    .mq2_i   (mQmin2_in_flat),
    .d_o     (cap_d),
    .mi1_o   (cap_mi1),
    .mq1_o   (cap_mq1),
    .mi2_o   (cap_mi2),
    .mq2_o   (cap_mq2),
    .full_o  (cap_full)
  );

  logic signed [ACC_WIDTH-1:0] d_arr [Q];
  logic [7:0]                  m_arr [Q];

  for (genvar i = 0; i < Q; i++) begin : g_unp
    assign d_arr[i] = cap_d[i*ACC_WIDTH +: ACC_WIDTH];
    assign m_arr[i] = {cap_mi1[2*i +: 2], cap_mq1[2*i +: 2],
                       cap_mi2[2*i +: 2], cap_mq2[2*i +: 2]};
  end

  state_t                      state_q, state_d;
  logic [QW-1:0]               idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0] best_d_q, best_d_d;
  logic [QW-1:0]               best_i_q, best_i_d;
  logic [7:0]                  best_m_q, best_m_d;
  logic signed [ACC_WIDTH-1:0] out_d_q, out_d_d;
  logic [QW-1:0]               out_i_q, out_i_d;
  logic [7:0]                  out_m_q, out_m_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;

  logic signed [ACC_WIDTH-1:0] nb_d;
  logic [QW-1:0]               nb_i;
  logic [7:0]                  nb_m;
  logic                        upd;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    best_d_d  = best_d_q;
    best_i_d  = best_i_q;
    best_m_d  = best_m_q;
    out_d_d   = out_d_q;
    out_i_d   = out_i_q;
    out_m_d   = out_m_q;
    valid_d   = 1'b0;
    cap_clear = 1'b0;
    cap_en    = 1'b0;

    // entry 0 seeds the scan; later entries need strict less
    upd  = (idx_q == '0) || (d_arr[idx_q] < best_d_q);
    nb_d = upd ? d_arr[idx_q] : best_d_q;
    nb_i = upd ? idx_q : best_i_q;
    nb_m = upd ? m_arr[idx_q] : best_m_q;

    unique case (state_q)
      IDLE: begin
        if (start_frame) begin
          cap_clear = 1'b1;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        cap_en = 1'b1;
        if (cap_full) begin
          state_d = COMPARE;
          idx_d   = '0;
        end
      end
      COMPARE: begin
        best_d_d = nb_d;
        best_i_d = nb_i;
        best_m_d = nb_m;
        idx_d    = idx_q + QW'(1);
        if (idx_q == QW'(Q-1)) begin
          out_d_d = nb_d;
          out_i_d = nb_i;
          out_m_d = nb_m;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      best_d_q <= '0;
      best_i_q <= '0;
      best_m_q <= '0;
      out_d_q  <= '0;
      out_i_q  <= '0;
      out_m_q  <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      best_d_q <= best_d_d;
      best_i_q <= best_i_d;
      best_m_q <= best_m_d;
      out_d_q  <= out_d_d;
      out_i_q  <= out_i_d;
      out_m_q  <= out_m_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign d_min_out  = out_d_q;
  assign q_best_out = out_i_q;
  assign mImin1_out = out_m_q[7:6];
  assign mQmin1_out = out_m_q[5:4];
  assign mImin2_out = out_m_q[3:2];
  assign mQmin2_out = out_m_q[1:0];
  assign valid_out  = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_min_dq_selector.sv
// Scoreboard bench: expected frame results are queued by the
// stimulus and popped by a monitor on each valid_out.
module tb_min_dq_selector;

  localparam int Q  = 8;
  localparam int AW = 48;

  typedef struct {
    longint d;
    int     q;
    int     mi1, mq1, mi2, mq2;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_frame;
  logic [Q-1:0]         pe_valid_in;
  logic [AW*Q-1:0]      d_q_in_flat;
  logic [2*Q-1:0]       mImin1_in_flat, mQmin1_in_flat;
  logic [2*Q-1:0]       mImin2_in_flat, mQmin2_in_flat;
  logic signed [AW-1:0] d_min_out;
  logic [2:0]           q_best_out;
  logic [1:0]           mImin1_out, mQmin1_out;
  logic [1:0]           mImin2_out, mQmin2_out;
  logic                 valid_out;
  logic                 busy;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  min_dq_selector #(.Q(Q), .ACC_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start_frame    (start_frame),
    .pe_valid_in    (pe_valid_in),
    .d_q_in_flat    (d_q_in_flat),
    .mImin1_in_flat (mImin1_in_flat),
    .mQmin1_in_flat (mQmin1_in_flat),
    .mImin2_in_flat (mImin2_in_flat),
    .mQmin2_in_flat (mQmin2_in_flat),
    .d_min_out      (d_min_out),
    .q_best_out     (q_best_out),
    .mImin1_out     (mImin1_out),
    .mQmin1_out     (mQmin1_out),
    .mImin2_out     (mImin2_out),
    .mQmin2_out     (mQmin2_out),
    .valid_out      (valid_out),
    .busy           (busy)
  );

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("d_min", longint'(d_min_out), e.d);
        chk("q_best", longint'(q_best_out), e.q);
        chk("mImin1", longint'(mImin1_out), e.mi1);
        chk("mQmin1", longint'(mQmin1_out), e.mq1);
        chk("mImin2", longint'(mImin2_out), e.mi2);
        chk("mQmin2", longint'(mQmin2_out), e.mq2);
      end
    end
  end

  task automatic push(input longint d, input int q,
                      input int a, input int b,
                      input int c, input int e);
    exp_t x;
    x.d = d; x.q = q;
    x.mi1 = a; x.mq1 = b; x.mi2 = c; x.mq2 = e;
    exp_q.push_back(x);
  endtask

  task automatic set_pe(input int i, input longint d,
                        input int off);
    d_q_in_flat[i*AW +: AW] = d[AW-1:0];
    mImin1_in_flat[2*i +: 2] = 2'((i + off) % 4);
    mQmin1_in_flat[2*i +: 2] = 2'((i + off + 1) % 4);
    mImin2_in_flat[2*i +: 2] = 2'((i + off + 2) % 4);
    mQmin2_in_flat[2*i +: 2] = 2'((i + off + 3) % 4);
  endtask

  task automatic start();
    @(negedge clk); start_frame = 1'b1;
    @(negedge clk); start_frame = 1'b0;
  endtask

  task automatic drive_valid(input logic [Q-1:0] v);
    @(negedge clk); pe_valid_in = v;
  endtask

  longint t1 [8] = '{100, 90, 80, 70, 60, 50, 40, 30};
  longint t2 [8] = '{11, 22, 33, -5, 44, 55, 66, 77};
  longint t3 [8] = '{40, 30, 10, 25, 15, 10, 35, 12};
  longint t5 [8] = '{-1, -2, -3, -4, 5, 6, 7, -4};
  logic [7:0] stag [20] = '{
    8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00,
    8'h00, 8'h08, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
    8'h20, 8'h00, 8'h40, 8'h00, 8'h00, 8'h80};

  initial begin
    rst = 1'b1;
    start_frame = 1'b0;
    pe_valid_in = '0;
    d_q_in_flat = '0;
    mImin1_in_flat = '0; mQmin1_in_flat = '0;
    mImin2_in_flat = '0; mQmin2_in_flat = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_d_min", longint'(d_min_out), 0);
    chk("rst_q_best", longint'(q_best_out), 0);
    chk("rst_valid", longint'(valid_out), 0);
    chk("rst_busy", longint'(busy), 0);

    // descending distances, all valid in one cycle
    for (int i = 0; i < Q; i++) set_pe(i, t1[i], 0);
    push(30, 7, 3, 0, 1, 2);
    start();
    chk("busy_collect", longint'(busy), 1);
    drive_valid(8'hFF);
    @(posedge clk);
    @(negedge clk); pe_valid_in = '0;
    chk("busy_compare", longint'(busy), 1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("lat_early", longint'(valid_out), 0);
    @(negedge clk);
    chk("lat_on", longint'(valid_out), 1);
    chk("busy_done", longint'(busy), 0);
    @(negedge clk);
    chk("lat_pulse", longint'(valid_out), 0);
    chk("hold_d_min", longint'(d_min_out), 30);

    // staggered captures, one negative distance
    for (int i = 0; i < Q; i++) set_pe(i, t2[i], 1);
    push(-5, 3, 0, 1, 2, 3);
    start();
    for (int k = 0; k < 20; k++) drive_valid(stag[k]);
    @(negedge clk); pe_valid_in = '0;
    repeat (10) @(negedge clk);

    // tie at the minimum keeps the lower index
    for (int i = 0; i < Q; i++) set_pe(i, t3[i], 2);
    push(10, 2, 0, 1, 2, 3);
    start();
    drive_valid(8'hFF);
    @(negedge clk); pe_valid_in = '0;
    repeat (10) @(negedge clk);

    // repeated valid from PE1 is ignored
    for (int i = 0; i < Q; i++) set_pe(i, 20, 3);
    set_pe(1, 50, 3);
    push(20, 0, 3, 0, 1, 2);
    start();
    drive_valid(8'h02);
    @(negedge clk); set_pe(1, 1, 3);
    drive_valid(8'hFF);
    @(negedge clk); pe_valid_in = '0;
    repeat (10) @(negedge clk);

    // reset while scanning idx=4 aborts the frame
    for (int i = 0; i < Q; i++) set_pe(i, t1[i], 0);
    start();
    drive_valid(8'hFF);
    @(posedge clk);
    @(negedge clk); pe_valid_in = '0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_d_min", longint'(d_min_out), 0);
    chk("abort_q_best", longint'(q_best_out), 0);
    chk("abort_m", longint'({mImin1_out, mQmin1_out,
                             mImin2_out, mQmin2_out}), 0);
    chk("abort_busy", longint'(busy), 0);
    repeat (10) @(negedge clk);

    for (int i = 0; i < Q; i++) set_pe(i, t5[i], 0);
    push(-4, 3, 3, 0, 1, 2);
    start();
    drive_valid(8'hFF);
    @(negedge clk); pe_valid_in = '0;
    repeat (10) @(negedge clk);

    // valids while idle start nothing
    drive_valid(8'hFF);
    drive_valid(8'h5A);
    @(negedge clk); pe_valid_in = '0;
    chk("idle_busy", longint'(busy), 0);
    repeat (3) @(negedge clk);

    // start_frame while busy leaves flags alone
    for (int i = 0; i < Q; i++) set_pe(i, 50, 1);
    set_pe(0, 5, 1);
    push(5, 0, 1, 2, 3, 0);
    start();
    drive_valid(8'h01);
    @(negedge clk);
    pe_valid_in = '0;
    start_frame = 1'b1;
    @(negedge clk);
    start_frame = 1'b0;
    set_pe(0, 100, 1);
    drive_valid(8'hFF);
    @(negedge clk);
    pe_valid_in = '0;
    start_frame = 1'b1;
    @(negedge clk); start_frame = 1'b0;
    repeat (10) @(negedge clk);
    chk("restart_busy", longint'(busy), 0);

    chk("scoreboard_empty", longint'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
